// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the wait-state counter width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wide enough for WAIT_STATES up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for loads/stores: byte enables, shifted write
// data, load extraction/extension. DMEM_MISALIGN_ERR_EN enables error detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic        is_byte;
  logic        is_half;
  logic        is_uns;
  logic [1:0]  offset;
  logic [31:0] rword_sh;

  // Anything that is not a legal byte/half code falls through to a word access.
  always_comb begin
    is_byte = (funct3 == F3_B) || (!we && (funct3 == F3_BU));
    is_half = (funct3 == F3_H) || (!we && (funct3 == F3_HU));
    is_uns  = funct3[2];
    if (is_byte) begin
      offset = addr_lo;
    end else if (is_half) begin
      offset = {addr_lo[1], 1'b0};
    end else begin
      offset = 2'b00;
    end
  end

`ifdef DMEM_MISALIGN_ERR_EN
  always_comb begin
    err = !(is_byte || is_half || (funct3 == F3_W))
          || (is_half && addr_lo[0])
          || (!is_byte && !is_half && (addr_lo != 2'b00));
  end
`else
  assign err = 1'b0;
`endif

  always_comb begin
    byte_en  = 4'b0000;
    wdata_sh = wdata << {offset, 3'b000};
    if (we && !err) begin
      if (is_byte) begin
        byte_en = 4'b0001 << offset;
      end else if (is_half) begin
        byte_en = 4'b0011 << offset;
      end else begin
        byte_en = 4'b1111;
      end
    end
  end

  always_comb begin
    rword_sh  = rword >> {offset, 3'b000};
    rdata_ext = '0;
    if (!we && !err) begin
      if (is_byte) begin
        rdata_ext = {{24{~is_uns & rword_sh[7]}}, rword_sh[7:0]};
      end else if (is_half) begin
        rdata_ext = {{16{~is_uns & rword_sh[15]}}, rword_sh[15:0]};
      end else begin
        rdata_ext = rword_sh;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory target with configurable wait states and lane-merged
// stores. Misalignment/illegal-funct3 errors are reported only with DMEM_MISALIGN_ERR_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               we_reg;
  logic [2:0]         funct3_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [31:0]        wdata_reg;
  logic [31:0]        rsp_rdata_reg;
  logic               rsp_err_reg;

  logic               accept;
  logic               commit;
  logic               op_we;
  logic [2:0]         op_funct3;
  logic [ADDR_W-1:0]  op_addr;
  logic [31:0]        op_wdata;
  logic [IDX_W-1:0]   op_idx;
  logic [31:0]        rd_word;
  logic [31:0]        wdata_sh;
  logic [31:0]        rdata_ext;
  logic [3:0]         byte_en;
  logic               err;

  assign req_ready = (state_reg == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_reg == DONE);
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  // With zero wait states the commit happens on the accept edge itself, so the
  // live request fields are used while idle and the latched copy otherwise.
  always_comb begin
    if (state_reg == IDLE) begin
      op_we     = req_we;
      op_funct3 = req_funct3;
      op_addr   = req_addr;
      op_wdata  = req_wdata;
    end else begin
      op_we     = we_reg;
      op_funct3 = funct3_reg;
      op_addr   = addr_reg;
      op_wdata  = wdata_reg;
    end
    op_idx = IDX_W'(op_addr[ADDR_W-1:2] % DEPTH);
  end

  dmem_lane_align u_align (
    .we        (op_we),
    .funct3    (op_funct3),
    .addr_lo   (op_addr[1:0]),
    .wdata     (op_wdata),
    .rword     (rd_word),
    .byte_en   (byte_en),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .err       (err)
  );

  // One byte-wide array per lane so each lane has a single writer.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (commit && byte_en[gi]) begin
        mem[op_idx] <= wdata_sh[gi*8 +: 8];
      end
    end

    assign rd_word[gi*8 +: 8] = mem[op_idx];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_next = DONE;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Reset wins over a commit that lands on the same edge.
    if (rst) begin
      commit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (commit) begin
        rsp_rdata_reg <= rdata_ext;
        rsp_err_reg   <= err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      addr_reg   <= req_addr;
      wdata_reg  <= req_wdata;
    end
  end

endmodule
